samsun_mem: RTL and testbench
=============================

SAMSUN_MEM -- requirements
Module: samsun_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning number of 32-bit words; power of two, 64..65536.
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning cycles from request accept to response; legal 1..4.
REQ-003 SHALL have parameter INIT_FILE, default "", meaning hex image loaded at time zero via readmemh; empty means no load.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_req_valid_i  in  1  instruction fetch request.
REQ-007 SHALL have port imem_req_pc_i  in  32  fetch byte address.
REQ-008 SHALL have port imem_req_ready_o  out  1  fetch accept.
REQ-009 SHALL have port imem_rsp_valid_o  out  1  fetch response valid.
REQ-010 SHALL have port imem_rsp_pc_o  out  32  pc of the returned instruction.
REQ-011 SHALL have port imem_rsp_instr_o  out  32  instruction word.
REQ-012 SHALL have port imem_rsp_err_o  out  1  fetch error (misaligned or out of range).
REQ-013 SHALL have port dmem_req_valid_i  in  1  data request.
REQ-014 SHALL have port dmem_req_ready_o  out  1  data accept.
REQ-015 SHALL have port dmem_wen_i  in  1  1 = write, 0 = read.
REQ-016 SHALL have port dmem_be_i  in  4  byte enables for writes.
REQ-017 SHALL have port dmem_addr_i  in  32  data byte address.
REQ-018 SHALL have port dmem_wdata_i  in  32  write data.
REQ-019 SHALL have port dmem_rsp_valid_o  out  1  data response valid, for reads and writes.
REQ-020 SHALL have port dmem_rdata_o  out  32  read data; 0 on write responses.
REQ-021 SHALL have port dmem_rsp_err_o  out  1  data error.

Function
REQ-022 SHALL accept a request on a port when valid and ready are both high in the same cycle; ready SHALL equal !rst_i, so both ports are fully pipelined with one request per cycle.
REQ-023 SHALL assert rsp_valid exactly RD_LATENCY cycles after accept, in order, one response per accepted request.
REQ-024 SHALL index memory with addr[2+$clog2(DEPTH_WORDS)-1:2].
REQ-025 SHALL flag err if addr[1:0] is not 0 or addr >= 4*DEPTH_WORDS; memory SHALL be unchanged, rdata and instr SHALL be 0, and rsp_valid SHALL still occur.
REQ-026 SHALL commit a write in its accept cycle, updating only the bytes whose be bit is 1; be equal to 0 SHALL leave memory unchanged and still produce a response.
REQ-027 SHALL sample read data in the accept cycle (read-before-write): a fetch or read of a word written in the same cycle returns the old value.
REQ-028 SHALL return the new value for a read accepted one or more cycles after the write.
REQ-029 SHALL make imem_rsp_pc_o equal to the accepted imem_req_pc_i.

Reset
REQ-030 SHALL, while rst_i is high at a clock edge, clear every pipeline stage: all rsp_valid, rsp_err, rdata, instr and rsp_pc outputs SHALL be 0 from the following cycle.
REQ-031 SHALL discard in-flight responses when reset asserts mid-operation; none of them is emitted after reset.
REQ-032 SHALL ignore requests presented during reset, including writes.
REQ-033 SHALL keep memory contents (the INIT_FILE image plus prior writes) across reset.

Structure
REQ-034 SHALL place in package samsun_mem_pkg: the mem_rsp_t struct (valid, err, data, pc), the constant WORD_BYTES=4, and the function be_merge(old, wdata, be).
REQ-035 SHALL implement the latency pipeline as sub-module samsun_mem_pipe (parameter RD_LATENCY, carries mem_rsp_t, with synchronous clear), instantiated once per port.

Verification
REQ-036 SHALL cover: RD_LATENCY=1, INIT word0=0x00500093, fetch pc 0x0 -> next cycle imem_rsp_valid=1, instr=0x00500093, pc=0x0.
REQ-037 SHALL cover: write 0xDEADBEEF to 0x10 with be=4'b0101, after preset 0x11223344 -> a read of 0x10 returns 0x11AD33EF.
REQ-038 SHALL cover: in one cycle, write 0xCAFEF00D to 0x20 and fetch 0x20 -> the fetch returns the old word, and a fetch on the next cycle returns 0xCAFEF00D.
REQ-039 SHALL cover: read 0x13, and with DEPTH_WORDS=512 read 0x800 -> rsp_err=1 and rdata=0 for both; a write to 0x800 leaves memory unchanged.
REQ-040 SHALL cover: RD_LATENCY=3, back-to-back reads 0x0, 0x4, 0x8 -> responses in cycles 3, 4 and 5, in order.
REQ-041 SHALL cover: RD_LATENCY=3, reset pulsed 1 cycle after 2 accepted reads -> no response is emitted after reset, and a prior write is still readable.

Source files
------------

// File: rtl/samsun_mem_pkg.sv
// ---------------------------------------------------------------------------
// samsun_mem_pkg
// Shared types and helpers for the samsun_mem dual-port (fetch + data)
// scratchpad memory.
//
// Contents:
//   WORD_BYTES  - number of bytes per memory word (4)
//   mem_rsp_t   - one response record carried down the latency pipeline
//                 (valid, err, data, pc)
//   RSP_IDLE    - all-zero response, used for reset and idle slots
//   be_merge    - byte-enable merge of write data into an old word
// ---------------------------------------------------------------------------
package samsun_mem_pkg;

   localparam int WORD_BYTES = 4;

   // A response as it travels through the latency pipeline. The pc field
   // carries the fetch address on the instruction side and is unused on
   // the data side.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
      logic [31:0] pc;
   } mem_rsp_t;

   localparam mem_rsp_t RSP_IDLE = '{valid: 1'b0, err: 1'b0, data: 32'h0, pc: 32'h0};

   // Replace only the bytes of the old word whose enable bit is set; a
   // zero enable mask returns the old word untouched.
   function automatic logic [31:0] be_merge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old;
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (be[b]) begin
            merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/samsun_mem_pipe.sv
// ---------------------------------------------------------------------------
// samsun_mem_pipe
// Fixed-latency shift pipeline for memory responses. A response presented
// on rspIn in the accept cycle appears on rspOut exactly RD_LATENCY cycles
// later. A synchronous reset empties every stage so nothing that was in
// flight is ever emitted afterwards.
//
// Ports:
//   clk_i   in   rising-edge clock
//   rst_i   in   synchronous active-high clear of all stages
//   rspIn   in   response built in the accept cycle
//   rspOut  out  response delayed by RD_LATENCY cycles
// ---------------------------------------------------------------------------
module samsun_mem_pipe
   import samsun_mem_pkg::*;
#(
   parameter int RD_LATENCY = 1
)(
   input  logic     clk_i,
   input  logic     rst_i,
   input  mem_rsp_t rspIn,
   output mem_rsp_t rspOut
);

   mem_rsp_t stages [RD_LATENCY];

   // Shift register of responses. Stage 0 captures the accept-cycle
   // response, each later stage takes its predecessor. Reset wipes every
   // stage at once, which is what discards in-flight responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < RD_LATENCY; s++) begin
            stages[s] <= RSP_IDLE;
         end
      end else begin
         stages[0] <= rspIn;
         for (int s = 1; s < RD_LATENCY; s++) begin
            stages[s] <= stages[s-1];
         end
      end
   end

   // The last stage is the externally visible response.
   assign rspOut = stages[RD_LATENCY-1];

endmodule

// File: rtl/samsun_mem.sv
// ---------------------------------------------------------------------------
// samsun_mem
// Word-organised memory with an instruction fetch port and a data port.
// Both ports accept one request per cycle whenever reset is low and return
// responses in order after a fixed RD_LATENCY. Reads sample the array in
// the accept cycle, so a same-cycle write is not visible to that read.
// Misaligned or out-of-range accesses return err with zero data and never
// modify the array. Array contents survive reset.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 64..65536)
//   RD_LATENCY   cycles from accept to response (1..4)
//   INIT_FILE    hex image loaded into the array at time zero, "" = none
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   imem_req_valid_i/pc_i           fetch request and byte address
//   imem_req_ready_o                fetch accept (= !rst_i)
//   imem_rsp_valid/pc/instr/err_o   fetch response
//   dmem_req_valid_i/ready_o        data request handshake
//   dmem_wen_i, dmem_be_i           write select and byte enables
//   dmem_addr_i, dmem_wdata_i       byte address and write data
//   dmem_rsp_valid/rdata/err_o      data response (rdata 0 for writes)
// ---------------------------------------------------------------------------
module samsun_mem
   import samsun_mem_pkg::*;
#(
   parameter int    DEPTH_WORDS = 512,
   parameter int    RD_LATENCY  = 1,
   parameter string INIT_FILE   = ""
)(
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        imem_req_valid_i,
   input  logic [31:0] imem_req_pc_i,
   output logic        imem_req_ready_o,
   output logic        imem_rsp_valid_o,
   output logic [31:0] imem_rsp_pc_o,
   output logic [31:0] imem_rsp_instr_o,
   output logic        imem_rsp_err_o,

   input  logic        dmem_req_valid_i,
   output logic        dmem_req_ready_o,
   input  logic        dmem_wen_i,
   input  logic [3:0]  dmem_be_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_wdata_i,
   output logic        dmem_rsp_valid_o,
   output logic [31:0] dmem_rdata_o,
   output logic        dmem_rsp_err_o
);

   localparam int          ADDR_BITS = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(WORD_BYTES * DEPTH_WORDS);

   logic [31:0]          memArray [DEPTH_WORDS];

   logic                 imemAccept;
   logic                 imemFault;
   logic [ADDR_BITS-1:0] imemIndex;
   mem_rsp_t             imemRspNext;
   mem_rsp_t             imemRsp;

   logic                 dmemAccept;
   logic                 dmemFault;
   logic                 dmemWriteCommit;
   logic [ADDR_BITS-1:0] dmemIndex;
   mem_rsp_t             dmemRspNext;
   mem_rsp_t             dmemRsp;
   logic [31:0]          unusedDmemPc;

   // An address is unusable when it is not word aligned or lies past the
   // end of the array; such accesses still get a response, flagged err.
   function automatic logic addrFault(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr >= MEM_BYTES);
   endfunction

   // Both ports are always ready outside reset, so the handshake reduces
   // to valid gated by !rst_i. Requests during reset are simply ignored.
   assign imem_req_ready_o = !rst_i;
   assign dmem_req_ready_o = !rst_i;
   assign imemAccept       = imem_req_valid_i && imem_req_ready_o;
   assign dmemAccept       = dmem_req_valid_i && dmem_req_ready_o;

   // Word index and fault decode for each port. Out-of-range addresses
   // alias onto a legal index, so every use of the index is qualified by
   // the fault flag.
   assign imemIndex       = imem_req_pc_i[2 +: ADDR_BITS];
   assign dmemIndex       = dmem_addr_i[2 +: ADDR_BITS];
   assign imemFault       = addrFault(imem_req_pc_i);
   assign dmemFault       = addrFault(dmem_addr_i);
   assign dmemWriteCommit = dmemAccept && dmem_wen_i && !dmemFault;

   // Fetch response built in the accept cycle. The array is read here,
   // before the write commits at the clock edge, which gives the
   // read-before-write behaviour for same-cycle collisions.
   always_comb begin
      imemRspNext = RSP_IDLE;
      if (imemAccept) begin
         imemRspNext.valid = 1'b1;
         imemRspNext.err   = imemFault;
         imemRspNext.pc    = imem_req_pc_i;
         if (!imemFault) begin
            imemRspNext.data = memArray[imemIndex];
         end
      end
   end

   // Data response built in the accept cycle. Writes and faulting
   // accesses answer with zero data; only a clean read returns the word.
   always_comb begin
      dmemRspNext = RSP_IDLE;
      if (dmemAccept) begin
         dmemRspNext.valid = 1'b1;
         dmemRspNext.err   = dmemFault;
         dmemRspNext.pc    = dmem_addr_i;
         if (!dmemFault && !dmem_wen_i) begin
            dmemRspNext.data = memArray[dmemIndex];
         end
      end
   end

   // Write port. Commits in the accept cycle with byte-enable merge. The
   // array deliberately has no reset so its contents persist across it.
   always_ff @(posedge clk_i) begin
      if (dmemWriteCommit) begin
         memArray[dmemIndex] <= be_merge(memArray[dmemIndex], dmem_wdata_i, dmem_be_i);
      end
   end

   samsun_mem_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) uImemPipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .rspIn  (imemRspNext),
      .rspOut (imemRsp)
   );

   samsun_mem_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) uDmemPipe (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .rspIn  (dmemRspNext),
      .rspOut (dmemRsp)
   );

   // Unpack the delayed responses onto the port outputs. The data side
   // carries an address in its pc slot that no output needs.
   assign imem_rsp_valid_o = imemRsp.valid;
   assign imem_rsp_err_o   = imemRsp.err;
   assign imem_rsp_instr_o = imemRsp.data;
   assign imem_rsp_pc_o    = imemRsp.pc;

   assign dmem_rsp_valid_o = dmemRsp.valid;
   assign dmem_rsp_err_o   = dmemRsp.err;
   assign dmem_rdata_o     = dmemRsp.data;
   assign unusedDmemPc     = dmemRsp.pc;

endmodule

// File: tb/tb_samsun_mem.sv
// ---------------------------------------------------------------------------
// tb_samsun_mem
// Two instances share one stimulus stream: dutLat1 (RD_LATENCY=1) is
// checked against a table of vectors, dutLat3 (RD_LATENCY=3) against
// hand-written pipelining and reset sequences.
// ---------------------------------------------------------------------------
module tb_samsun_mem;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   logic        imemValid;
   logic [31:0] imemPc;
   logic        dmemValid;
   logic        dmemWen;
   logic [3:0]  dmemBe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;

   logic        l1IReady, l1IValid, l1IErr;
   logic [31:0] l1IPc, l1Instr;
   logic        l1DReady, l1DValid, l1DErr;
   logic [31:0] l1Rdata;

   logic        l3IReady, l3IValid, l3IErr;
   logic [31:0] l3IPc, l3Instr;
   logic        l3DReady, l3DValid, l3DErr;
   logic [31:0] l3Rdata;

   int checksTotal  = 0;
   int checksPassed = 0;

   samsun_mem #(.DEPTH_WORDS(512), .RD_LATENCY(1), .INIT_FILE("")) dutLat1 (
      .clk_i(clock), .rst_i(reset),
      .imem_req_valid_i(imemValid), .imem_req_pc_i(imemPc), .imem_req_ready_o(l1IReady),
      .imem_rsp_valid_o(l1IValid), .imem_rsp_pc_o(l1IPc), .imem_rsp_instr_o(l1Instr),
      .imem_rsp_err_o(l1IErr),
      .dmem_req_valid_i(dmemValid), .dmem_req_ready_o(l1DReady), .dmem_wen_i(dmemWen),
      .dmem_be_i(dmemBe), .dmem_addr_i(dmemAddr), .dmem_wdata_i(dmemWdata),
      .dmem_rsp_valid_o(l1DValid), .dmem_rdata_o(l1Rdata), .dmem_rsp_err_o(l1DErr)
   );

   samsun_mem #(.DEPTH_WORDS(512), .RD_LATENCY(3), .INIT_FILE("")) dutLat3 (
      .clk_i(clock), .rst_i(reset),
      .imem_req_valid_i(imemValid), .imem_req_pc_i(imemPc), .imem_req_ready_o(l3IReady),
      .imem_rsp_valid_o(l3IValid), .imem_rsp_pc_o(l3IPc), .imem_rsp_instr_o(l3Instr),
      .imem_rsp_err_o(l3IErr),
      .dmem_req_valid_i(dmemValid), .dmem_req_ready_o(l3DReady), .dmem_wen_i(dmemWen),
      .dmem_be_i(dmemBe), .dmem_addr_i(dmemAddr), .dmem_wdata_i(dmemWdata),
      .dmem_rsp_valid_o(l3DValid), .dmem_rdata_o(l3Rdata), .dmem_rsp_err_o(l3DErr)
   );

   typedef struct packed {
      logic        iValid;
      logic [31:0] iPc;
      logic        dValid;
      logic        dWen;
      logic [3:0]  dBe;
      logic [31:0] dAddr;
      logic [31:0] dWdata;
      logic        expIValid;
      logic        expIErr;
      logic [31:0] expInstr;
      logic        expDValid;
      logic        expDErr;
      logic [31:0] expRdata;
   } vector_t;

   localparam int NUM_VECTORS = 12;
   vector_t vectors [NUM_VECTORS];

   // One comparison: counts it, reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checksTotal++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end else begin
         checksPassed++;
      end
   endtask

   // Drive both request ports from one vector.
   task automatic applyStimulus(input vector_t v);
      imemValid = v.iValid;
      imemPc    = v.iPc;
      dmemValid = v.dValid;
      dmemWen   = v.dWen;
      dmemBe    = v.dBe;
      dmemAddr  = v.dAddr;
      dmemWdata = v.dWdata;
   endtask

   task automatic driveIdle();
      imemValid = 1'b0;
      imemPc    = 32'h0;
      dmemValid = 1'b0;
      dmemWen   = 1'b0;
      dmemBe    = 4'h0;
      dmemAddr  = 32'h0;
      dmemWdata = 32'h0;
   endtask

   task automatic driveData(input logic wen, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
      dmemValid = 1'b1;
      dmemWen   = wen;
      dmemBe    = be;
      dmemAddr  = addr;
      dmemWdata = wdata;
   endtask

   logic [31:0] burstWords [3];

   initial begin
      //         iV  iPc           dV  wen be    dAddr         dWdata        eIV eIE eInstr        eDV eDE eRdata
      vectors[0]  = {1'b0, 32'h0,    1'b1, 1'b1, 4'hF, 32'h0,    32'h00500093, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
      vectors[1]  = {1'b1, 32'h0,    1'b1, 1'b1, 4'hF, 32'h10,   32'h11223344, 1'b1, 1'b0, 32'h00500093, 1'b1, 1'b0, 32'h0};
      vectors[2]  = {1'b1, 32'h13,   1'b1, 1'b1, 4'hF, 32'h20,   32'h01234567, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
      vectors[3]  = {1'b1, 32'h10,   1'b1, 1'b1, 4'h5, 32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 32'h11223344, 1'b1, 1'b0, 32'h0};
      vectors[4]  = {1'b1, 32'h800,  1'b1, 1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h11AD33EF};
      vectors[5]  = {1'b1, 32'h20,   1'b1, 1'b1, 4'hF, 32'h20,   32'hCAFEF00D, 1'b1, 1'b0, 32'h01234567, 1'b1, 1'b0, 32'h0};
      vectors[6]  = {1'b1, 32'h20,   1'b1, 1'b0, 4'h0, 32'h13,   32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0};
      vectors[7]  = {1'b0, 32'h0,    1'b1, 1'b0, 4'h0, 32'h800,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
      vectors[8]  = {1'b0, 32'h0,    1'b1, 1'b1, 4'hF, 32'h800,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
      vectors[9]  = {1'b1, 32'h0,    1'b1, 1'b1, 4'h0, 32'h0,    32'h55555555, 1'b1, 1'b0, 32'h00500093, 1'b1, 1'b0, 32'h0};
      vectors[10] = {1'b1, 32'h10,   1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h11AD33EF, 1'b1, 1'b0, 32'h00500093};
      vectors[11] = {1'b0, 32'h0,    1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};

      burstWords[0] = 32'h00500093;
      burstWords[1] = 32'h44444444;
      burstWords[2] = 32'h88888888;

      // Reset with requests idle; outputs of both instances must be zero.
      driveIdle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst.l1.iValid", 32'(l1IValid), 32'h0);
      checkOutput("rst.l1.dValid", 32'(l1DValid), 32'h0);
      checkOutput("rst.l1.iReady", 32'(l1IReady), 32'h0);
      checkOutput("rst.l1.dReady", 32'(l1DReady), 32'h0);
      checkOutput("rst.l3.dValid", 32'(l3DValid), 32'h0);
      checkOutput("rst.l3.rdata",  l3Rdata,       32'h0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("run.l1.iReady", 32'(l1IReady), 32'h1);

      // Latency-1 table: each vector's response is visible one edge later.
      for (int i = 0; i < NUM_VECTORS; i++) begin
         @(negedge clock);
         applyStimulus(vectors[i]);
         @(posedge clock);
         #1;
         checkOutput($sformatf("v%0d.iValid", i), 32'(l1IValid), 32'(vectors[i].expIValid));
         checkOutput($sformatf("v%0d.iErr", i),   32'(l1IErr),   32'(vectors[i].expIErr));
         checkOutput($sformatf("v%0d.instr", i),  l1Instr,       vectors[i].expInstr);
         checkOutput($sformatf("v%0d.iPc", i),    l1IPc,         vectors[i].iValid ? vectors[i].iPc : 32'h0);
         checkOutput($sformatf("v%0d.dValid", i), 32'(l1DValid), 32'(vectors[i].expDValid));
         checkOutput($sformatf("v%0d.dErr", i),   32'(l1DErr),   32'(vectors[i].expDErr));
         checkOutput($sformatf("v%0d.rdata", i),  l1Rdata,       vectors[i].expRdata);
      end

      // Latency-3 burst: preload 0x4/0x8, drain, then reads in cycles 0..2
      // must answer in cycles 3..5 in order.
      @(negedge clock);
      driveData(1'b1, 4'hF, 32'h4, 32'h44444444);
      @(negedge clock);
      driveData(1'b1, 4'hF, 32'h8, 32'h88888888);
      @(negedge clock);
      driveIdle();
      repeat (4) @(negedge clock);
      for (int cyc = 0; cyc < 7; cyc++) begin
         if (cyc < 3) begin
            driveData(1'b0, 4'h0, 32'(cyc * 4), 32'h0);
         end else begin
            driveIdle();
         end
         @(posedge clock);
         #1;
         if ((cyc + 1) >= 3 && (cyc + 1) <= 5) begin
            checkOutput($sformatf("burst.c%0d.valid", cyc + 1), 32'(l3DValid), 32'h1);
            checkOutput($sformatf("burst.c%0d.rdata", cyc + 1), l3Rdata, burstWords[cyc - 2]);
         end else begin
            checkOutput($sformatf("burst.c%0d.valid", cyc + 1), 32'(l3DValid), 32'h0);
         end
         @(negedge clock);
      end

      // Latency-3 reset: write a marker, accept two reads, then pulse reset
      // with a clobbering write and a fetch that must both be ignored.
      driveData(1'b1, 4'hF, 32'h30, 32'hA5A5A5A5);
      @(negedge clock);
      driveIdle();
      repeat (4) @(negedge clock);
      driveData(1'b0, 4'h0, 32'h4, 32'h0);
      @(negedge clock);
      driveData(1'b0, 4'h0, 32'h8, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      driveData(1'b1, 4'hF, 32'h30, 32'h0);
      imemValid = 1'b1;
      imemPc    = 32'h0;
      #1;
      checkOutput("rstMid.dReady", 32'(l3DReady), 32'h0);
      checkOutput("rstMid.iReady", 32'(l3IReady), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("rstMid.cleared.dValid", 32'(l3DValid), 32'h0);
      checkOutput("rstMid.cleared.iValid", 32'(l3IValid), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      driveIdle();
      for (int k = 0; k < 6; k++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("postRst.c%0d.dValid", k), 32'(l3DValid), 32'h0);
         checkOutput($sformatf("postRst.c%0d.iValid", k), 32'(l3IValid), 32'h0);
      end
      @(negedge clock);
      driveData(1'b0, 4'h0, 32'h30, 32'h0);
      @(negedge clock);
      driveIdle();
      @(posedge clock);
      #1;
      checkOutput("marker.lat2.dValid", 32'(l3DValid), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("marker.lat3.dValid", 32'(l3DValid), 32'h1);
      checkOutput("marker.lat3.rdata",  l3Rdata,       32'hA5A5A5A5);
      checkOutput("marker.lat3.dErr",   32'(l3DErr),   32'h0);

      repeat (2) @(posedge clock);
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
